fifo_prog_sync: RTL and testbench

// - Parametrised synchronous FIFO; successor to the fixed 16x8 FIFO.
// - Adds runtime-programmable almost-full/almost-empty thresholds, an occupancy count,
//   non-power-of-two depth and a first-word-fall-through (FWFT) read mode.
// - Used as the generic buffer between producer/consumer stages in one clock domain.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/fifo_ram_sdp.sv | 30 +++
 rtl/fifo_prog_sync.sv | 127 ++++++++++++
 tb/tb_fifo_prog_sync.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the programmable synchronous FIFO.
//   clog2_cnt()  - width needed to hold an occupancy of 0..depth
//   fifo_mode_e  - read-port mode (registered or first-word-fall-through)
//   mode_of()    - maps the integer FWFT parameter onto fifo_mode_e
package fifo_pkg;

  // Type used for width values produced by clog2_cnt.
  typedef int unsigned fifo_cnt_w_t;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // The count must reach depth itself, hence depth+1 states.
  function automatic fifo_cnt_w_t clog2_cnt(input int depth);
    return fifo_cnt_w_t'($clog2(depth + 1));
  endfunction

  function automatic fifo_mode_e mode_of(input int fwft);
    return (fwft != 0) ? FIFO_FWFT : FIFO_STD;
  endfunction

endpackage

// File: rtl/fifo_ram_sdp.sv
// fifo_ram_sdp: simple dual-port storage, one synchronous write port and one
// asynchronous read port. Contents are never reset.
//   clk    in  clock, rising edge
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   raddr  in  read address
//   rdata  out read data (combinational from raddr)
module fifo_ram_sdp #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_prog_sync.sv
// fifo_prog_sync: parametrised single-clock FIFO with programmable
// almost-full/almost-empty thresholds, occupancy count, arbitrary depth and
// optional first-word-fall-through read port.
//   clk, rst_n              clock (rising) and async active-low reset
//   data_in, wr_en          write data / request
//   rd_en                   pop request
//   af_thresh, ae_thresh    almost-full (count >= af) / almost-empty (count <= ae)
//   data_out, rd_valid      read data and its valid
//   wr_ack, overflow        one-cycle pulses: previous write accepted / rejected
//   underflow               one-cycle pulse: previous read rejected (empty)
//   full, empty, almostfull, almostempty, count   occupancy status
module fifo_prog_sync
  import fifo_pkg::*;
#(
  parameter  int FIFO_WIDTH = 16,
  parameter  int FIFO_DEPTH = 8,
  parameter  int FWFT       = 0,
  localparam int CNT_W      = int'(clog2_cnt(FIFO_DEPTH))
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [CNT_W-1:0]      af_thresh,
  input  logic [CNT_W-1:0]      ae_thresh,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CNT_W-1:0]      count
);

  localparam int               PTR_W   = $clog2(FIFO_DEPTH);
  localparam fifo_mode_e       MODE    = mode_of(FWFT);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(FIFO_DEPTH - 1);

  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic                  wr_ok, rd_ok;
  logic [FIFO_WIDTH-1:0] ram_rdata;

  // Depth need not be a power of two, so wrap on an explicit compare.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_C) ? '0 : p + PTR_W'(1);
  endfunction

  // Status flags come straight from the registered count so a threshold
  // change is reflected in the same cycle. A zero af_thresh and an
  // ae_thresh at or above the depth fall out of the compares naturally.
  assign full        = (count == DEPTH_C);
  assign empty       = (count == '0);
  assign almostfull  = (count >= af_thresh);
  assign almostempty = (count <= ae_thresh);

  // A write into a full FIFO is still accepted when a pop frees a slot in
  // the same edge; a read of an empty FIFO is never bypassed from data_in.
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);

  fifo_ram_sdp #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  // ---- stage p1: pointers, occupancy and handshake pulses ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_ok) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      wr_ack    <= wr_ok;
      overflow  <= wr_en & ~wr_ok;
      underflow <= rd_en & empty;
    end
  end

  generate
    if (MODE == FIFO_FWFT) begin : g_fwft
      // Head word is always on display; rd_en consumes it at the edge.
      assign data_out = ram_rdata;
      assign rd_valid = ~empty;
    end else begin : g_std
      logic [FIFO_WIDTH-1:0] rd_data_p1;
      logic                  vld_p1;

      // ---- stage p1: registered read data ----
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data_p1 <= '0;
          vld_p1     <= 1'b0;
        end else begin
          vld_p1 <= rd_ok;
          if (rd_ok) rd_data_p1 <= ram_rdata;
        end
      end

      assign data_out = rd_data_p1;
      assign rd_valid = vld_p1;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_prog_sync.sv
// tb_fifo_prog_sync: directed bench for fifo_prog_sync using three instances:
// depth 8 registered read, depth 5 registered read, depth 4 FWFT.
module tb_fifo_prog_sync;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // depth 8, registered read
  logic [15:0] d8_din, d8_dout;
  logic        d8_wr, d8_rd, d8_rv, d8_ack, d8_ovf, d8_udf, d8_full, d8_empty, d8_afl, d8_ael;
  logic [3:0]  d8_af, d8_ae, d8_cnt;

  // depth 5, registered read
  logic [15:0] d5_din, d5_dout;
  logic        d5_wr, d5_rd, d5_rv, d5_ack, d5_ovf, d5_udf, d5_full, d5_empty, d5_afl, d5_ael;
  logic [2:0]  d5_af, d5_ae, d5_cnt;

  // depth 4, first-word-fall-through
  logic [15:0] fw_din, fw_dout;
  logic        fw_wr, fw_rd, fw_rv, fw_ack, fw_ovf, fw_udf, fw_full, fw_empty, fw_afl, fw_ael;
  logic [2:0]  fw_af, fw_ae, fw_cnt;

  fifo_prog_sync #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(0)) u_d8 (
    .clk(clk), .rst_n(rst_n), .data_in(d8_din), .wr_en(d8_wr), .rd_en(d8_rd),
    .af_thresh(d8_af), .ae_thresh(d8_ae), .data_out(d8_dout), .rd_valid(d8_rv),
    .wr_ack(d8_ack), .overflow(d8_ovf), .underflow(d8_udf), .full(d8_full),
    .empty(d8_empty), .almostfull(d8_afl), .almostempty(d8_ael), .count(d8_cnt));

  fifo_prog_sync #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .FWFT(0)) u_d5 (
    .clk(clk), .rst_n(rst_n), .data_in(d5_din), .wr_en(d5_wr), .rd_en(d5_rd),
    .af_thresh(d5_af), .ae_thresh(d5_ae), .data_out(d5_dout), .rd_valid(d5_rv),
    .wr_ack(d5_ack), .overflow(d5_ovf), .underflow(d5_udf), .full(d5_full),
    .empty(d5_empty), .almostfull(d5_afl), .almostempty(d5_ael), .count(d5_cnt));

  fifo_prog_sync #(.FIFO_WIDTH(16), .FIFO_DEPTH(4), .FWFT(1)) u_fw (
    .clk(clk), .rst_n(rst_n), .data_in(fw_din), .wr_en(fw_wr), .rd_en(fw_rd),
    .af_thresh(fw_af), .ae_thresh(fw_ae), .data_out(fw_dout), .rd_valid(fw_rv),
    .wr_ack(fw_ack), .overflow(fw_ovf), .underflow(fw_udf), .full(fw_full),
    .empty(fw_empty), .almostfull(fw_afl), .almostempty(fw_ael), .count(fw_cnt));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    d8_din = '0; d8_wr = 0; d8_rd = 0; d8_af = 4'd6; d8_ae = 4'd2;
    d5_din = '0; d5_wr = 0; d5_rd = 0; d5_af = 3'd4; d5_ae = 3'd1;
    fw_din = '0; fw_wr = 0; fw_rd = 0; fw_af = 3'd3; fw_ae = 3'd1;

    // ---- reset state ----
    tick(); tick();
    check_eq("rst_empty", 32'(d8_empty), 32'd1);
    check_eq("rst_full",  32'(d8_full),  32'd0);
    check_eq("rst_count", 32'(d8_cnt),   32'd0);
    check_eq("rst_pulses", 32'({d8_ack, d8_ovf, d8_udf, d8_rv}), 32'd0);
    check_eq("rst_dout",  32'(d8_dout),  32'd0);
    rst_n = 1'b1;
    tick();

    // ---- depth 8 fill with thresholds af=6 ae=2 ----
    for (int i = 1; i <= 8; i++) begin
      d8_wr = 1; d8_din = 16'(i);
      tick();
      check_eq($sformatf("fill_cnt%0d", i), 32'(d8_cnt), 32'(i));
      check_eq($sformatf("fill_ack%0d", i), 32'(d8_ack), 32'd1);
      if (i == 2) check_eq("ae_at2", 32'(d8_ael), 32'd1);
      if (i == 3) check_eq("ae_at3", 32'(d8_ael), 32'd0);
      if (i == 5) check_eq("af_at5", 32'(d8_afl), 32'd0);
      if (i == 6) check_eq("af_at6", 32'(d8_afl), 32'd1);
      if (i == 7) begin
        d8_af = 4'd8; #1;
        check_eq("af_thr8_at7", 32'(d8_afl), 32'd0);
        d8_af = 4'd0; #1;
        check_eq("af_thr0", 32'(d8_afl), 32'd1);
        d8_ae = 4'd8; #1;
        check_eq("ae_thr8", 32'(d8_ael), 32'd1);
        d8_af = 4'd6; d8_ae = 4'd2; #1;
      end
    end
    check_eq("full_at8", 32'(d8_full), 32'd1);

    // 9th write is rejected
    d8_din = 16'h00FF;
    tick();
    check_eq("ovf_pulse", 32'(d8_ovf), 32'd1);
    check_eq("ovf_ack",   32'(d8_ack), 32'd0);
    check_eq("ovf_cnt",   32'(d8_cnt), 32'd8);

    // full with simultaneous read and write
    d8_din = 16'h0009; d8_rd = 1;
    tick();
    check_eq("fullrw_cnt",  32'(d8_cnt),  32'd8);
    check_eq("fullrw_ack",  32'(d8_ack),  32'd1);
    check_eq("fullrw_ovf",  32'(d8_ovf),  32'd0);
    check_eq("fullrw_rv",   32'(d8_rv),   32'd1);
    check_eq("fullrw_dout", 32'(d8_dout), 32'h0001);
    check_eq("ovf_dropped", 32'(d8_ovf),  32'd0);

    // drain: 2..8 then the word written during the full read/write
    d8_wr = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq($sformatf("drain%0d", i), 32'(d8_dout), (i == 7) ? 32'h0009 : 32'(i + 2));
    end
    check_eq("drain_empty", 32'(d8_empty), 32'd1);
    tick();
    check_eq("udf_pulse", 32'(d8_udf),  32'd1);
    check_eq("udf_rv",    32'(d8_rv),   32'd0);
    check_eq("udf_hold",  32'(d8_dout), 32'h0009);
    check_eq("udf_cnt",   32'(d8_cnt),  32'd0);

    // empty with simultaneous read and write: write lands, read underflows
    d8_wr = 1; d8_din = 16'h0077;
    tick();
    check_eq("emprw_cnt", 32'(d8_cnt), 32'd1);
    check_eq("emprw_udf", 32'(d8_udf), 32'd1);
    check_eq("emprw_ack", 32'(d8_ack), 32'd1);
    check_eq("emprw_rv",  32'(d8_rv),  32'd0);
    d8_wr = 0;
    tick();
    check_eq("emprw_pop", 32'(d8_dout), 32'h0077);
    d8_rd = 0;

    // ---- depth 5: interleaved traffic wraps the pointers ----
    for (int k = 0; k < 12; k++) begin
      d5_wr = 1; d5_din = 16'(16'h0100 + k); d5_rd = (k >= 3);
      tick();
      if (k >= 3) begin
        check_eq($sformatf("d5_data%0d", k), 32'(d5_dout), 32'(16'h0100 + k - 3));
        check_eq($sformatf("d5_cnt%0d", k),  32'(d5_cnt),  32'd3);
      end
    end
    d5_wr = 0;
    for (int k = 9; k < 12; k++) begin
      tick();
      check_eq($sformatf("d5_tail%0d", k), 32'(d5_dout), 32'(16'h0100 + k));
    end
    d5_rd = 0;
    check_eq("d5_empty", 32'(d5_empty), 32'd1);
    for (int k = 0; k < 5; k++) begin
      d5_wr = 1; d5_din = 16'(k);
      tick();
    end
    d5_wr = 0;
    check_eq("d5_full", 32'(d5_full), 32'd1);
    check_eq("d5_cnt5", 32'(d5_cnt),  32'd5);

    // ---- FWFT ----
    fw_wr = 1; fw_din = 16'hABCD;
    tick();
    fw_wr = 0;
    check_eq("fw_rv",   32'(fw_rv),   32'd1);
    check_eq("fw_dout", 32'(fw_dout), 32'hABCD);
    check_eq("fw_cnt1", 32'(fw_cnt),  32'd1);
    fw_rd = 1;
    tick();
    check_eq("fw_pop_cnt", 32'(fw_cnt), 32'd0);
    check_eq("fw_pop_rv",  32'(fw_rv),  32'd0);
    tick();
    check_eq("fw_udf",     32'(fw_udf), 32'd1);
    check_eq("fw_udf_cnt", 32'(fw_cnt), 32'd0);
    fw_rd = 0; fw_wr = 1; fw_din = 16'h1111;
    tick();
    fw_din = 16'h2222;
    tick();
    fw_wr = 0;
    check_eq("fw_head1", 32'(fw_dout), 32'h1111);
    fw_rd = 1;
    tick();
    fw_rd = 0;
    check_eq("fw_head2", 32'(fw_dout), 32'h2222);

    // ---- reset in the middle of a write burst ----
    d8_wr = 1; d8_din = 16'h0055;
    tick(); tick();
    check_eq("mid_pre_ack", 32'(d8_ack), 32'd1);
    rst_n = 1'b0; #1;
    check_eq("mid_empty", 32'(d8_empty), 32'd1);
    check_eq("mid_count", 32'(d8_cnt),   32'd0);
    check_eq("mid_pulses", 32'({d8_ack, d8_ovf, d8_udf, d8_rv}), 32'd0);
    check_eq("mid_fw_cnt", 32'(fw_cnt),  32'd0);
    d8_wr = 0;
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_count", 32'(d8_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
